// File: rtl/amber128_wb_arbiter.sv
// Writeback arbiter: merges ALU results and queued LSU load returns into one registered
// register-file write per cycle, bounds load starvation and tracks pending loads.
module amber128_wb_arbiter #(
    parameter int unsigned XLEN         = 128,
    parameter int unsigned NREGS        = 32,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned RW          = $clog2(NREGS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             alu_valid_i,
    input  logic [RW-1:0]    alu_rw_i,
    input  logic [XLEN-1:0]  alu_wd_i,
    output logic             alu_stall_o,
    input  logic             lsu_valid_i,
    output logic             lsu_ready_o,
    input  logic [RW-1:0]    lsu_rw_i,
    input  logic [XLEN-1:0]  lsu_wd_i,
    input  logic             ld_issue_i,
    input  logic [RW-1:0]    ld_issue_rw_i,
    output logic [NREGS-1:0] pend_o,
    output logic             wb_valid_o,
    output logic             wb_we_o,
    output logic [RW-1:0]    wb_rw_o,
    output logic [XLEN-1:0]  wb_wd_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [RW-1:0]   rw;
        logic [XLEN-1:0] wd;
    } ld_entry_t;

    ld_entry_t         mem_q [FIFO_DEPTH];
    ld_entry_t         mem_d [FIFO_DEPTH];
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              stall_q, stall_d;
    logic              ready_q, ready_d;
    logic [NREGS-1:0]  pend_q, pend_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_we_q, wb_we_d;
    logic [RW-1:0]     wb_rw_q, wb_rw_d;
    logic [XLEN-1:0]   wb_wd_q, wb_wd_d;

    logic              push, pop, alu_win, fifo_ne;
    ld_entry_t         head;

    // Arbitration, FIFO bookkeeping, starvation guard and pending-load scoreboard.
    always_comb begin
        mem_d      = mem_q;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        starve_d   = starve_q;
        pend_d     = pend_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rw_d    = wb_rw_q;
        wb_wd_d    = wb_wd_q;
        pop        = 1'b0;
        alu_win    = 1'b0;
        fifo_ne    = (count_q != '0);
        head       = mem_q[rptr_q];
        push       = lsu_valid_i && ready_q;

        // A stall cycle always serves the FIFO; any ALU result presented then is dropped.
        if (stall_q) begin
            pop = fifo_ne;
        end else if (alu_valid_i) begin
            alu_win = 1'b1;
        end else begin
            pop = fifo_ne;
        end

        if (alu_win) begin
            wb_valid_d = 1'b1;
            wb_we_d    = (alu_rw_i != '0);
            wb_rw_d    = alu_rw_i;
            wb_wd_d    = alu_wd_i;
        end else if (pop) begin
            wb_valid_d = 1'b1;
            wb_we_d    = (head.rw != '0);
            wb_rw_d    = head.rw;
            wb_wd_d    = head.wd;
        end

        if (push) begin
            mem_d[wptr_q] = '{rw: lsu_rw_i, wd: lsu_wd_i};
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        ready_d = (count_d < CW'(FIFO_DEPTH));

        if (pop || !fifo_ne) begin
            starve_d = '0;
        end else if (alu_win) begin
            starve_d = starve_q + SW'(1);
        end
        stall_d = (starve_d >= SW'(STARVE_LIMIT));

        // Clear on retire first so a same-cycle reissue to that register wins.
        if (pop) begin
            pend_d[head.rw] = 1'b0;
        end
        if (ld_issue_i && (ld_issue_rw_i != '0)) begin
            pend_d[ld_issue_rw_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q      <= '{default: '0};
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
            ready_q    <= 1'b0;
            pend_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rw_q    <= '0;
            wb_wd_q    <= '0;
        end else begin
            mem_q      <= mem_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            ready_q    <= ready_d;
            pend_q     <= pend_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rw_q    <= wb_rw_d;
            wb_wd_q    <= wb_wd_d;
        end
    end

    assign alu_stall_o = stall_q;
    assign lsu_ready_o = ready_q;
    assign pend_o      = pend_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_we_o     = wb_we_q;
    assign wb_rw_o     = wb_rw_q;
    assign wb_wd_o     = wb_wd_q;

endmodule

// File: tb/tb_amber128_wb_arbiter.sv
// Bench for amber128_wb_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_amber128_wb_arbiter;

    localparam int unsigned XLEN  = 128;
    localparam int unsigned NREGS = 32;
    localparam int unsigned RW    = 5;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             alu_valid_i;
    logic [RW-1:0]    alu_rw_i;
    logic [XLEN-1:0]  alu_wd_i;
    logic             alu_stall_o;
    logic             lsu_valid_i;
    logic             lsu_ready_o;
    logic [RW-1:0]    lsu_rw_i;
    logic [XLEN-1:0]  lsu_wd_i;
    logic             ld_issue_i;
    logic [RW-1:0]    ld_issue_rw_i;
    logic [NREGS-1:0] pend_o;
    logic             wb_valid_o;
    logic             wb_we_o;
    logic [RW-1:0]    wb_rw_o;
    logic [XLEN-1:0]  wb_wd_o;

    int nchk = 0;
    int nerr = 0;

    amber128_wb_arbiter dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .alu_valid_i   (alu_valid_i),
        .alu_rw_i      (alu_rw_i),
        .alu_wd_i      (alu_wd_i),
        .alu_stall_o   (alu_stall_o),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_rw_i      (lsu_rw_i),
        .lsu_wd_i      (lsu_wd_i),
        .ld_issue_i    (ld_issue_i),
        .ld_issue_rw_i (ld_issue_rw_i),
        .pend_o        (pend_o),
        .wb_valid_o    (wb_valid_o),
        .wb_we_o       (wb_we_o),
        .wb_rw_o       (wb_rw_o),
        .wb_wd_o       (wb_wd_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: loads live in a queue, outputs are what the rules say they must be.
    typedef struct {
        logic [RW-1:0]   rw;
        logic [XLEN-1:0] wd;
    } ent_t;

    ent_t             mq[$];
    logic             e_valid = 1'b0, e_we = 1'b0, e_stall = 1'b0, e_ready = 1'b0;
    logic [RW-1:0]    e_rw = '0;
    logic [XLEN-1:0]  e_wd = '0;
    logic [NREGS-1:0] e_pend = '0;
    int               starve = 0;

    initial begin
        logic ne, pop, alu, push;
        ent_t h;
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) begin
                mq.delete();
                e_valid = 1'b0; e_we = 1'b0; e_rw = '0; e_wd = '0;
                e_pend = '0; e_stall = 1'b0; e_ready = 1'b0; starve = 0;
            end else begin
                assert (!(alu_valid_i && alu_stall_o))
                else begin
                    nerr++;
                    $display("FAIL protocol: ALU result presented during stall at %0t", $time);
                end
                ne   = (mq.size() > 0);
                pop  = 1'b0;
                alu  = 1'b0;
                push = lsu_valid_i && e_ready;
                if (e_stall)          pop = ne;
                else if (alu_valid_i) alu = 1'b1;
                else                  pop = ne;
                if (alu) begin
                    e_valid = 1'b1; e_we = (alu_rw_i != 0); e_rw = alu_rw_i; e_wd = alu_wd_i;
                end else if (pop) begin
                    h = mq.pop_front();
                    e_valid = 1'b1; e_we = (h.rw != 0); e_rw = h.rw; e_wd = h.wd;
                    e_pend[h.rw] = 1'b0;
                end else begin
                    e_valid = 1'b0; e_we = 1'b0;
                end
                if (ld_issue_i && ld_issue_rw_i != 0) e_pend[ld_issue_rw_i] = 1'b1;
                if (push) mq.push_back('{rw: lsu_rw_i, wd: lsu_wd_i});
                if (pop || !ne) starve = 0;
                else if (alu)   starve++;
                e_stall = (starve == LIMIT);
                e_ready = (mq.size() < DEPTH);
            end
        end
    end

    // Compare every output against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk_i);
            check("wb_valid", wb_valid_o, e_valid);
            check("wb_we", wb_we_o, e_we);
            check("wb_rw", wb_rw_o, e_rw);
            check("wb_wd", wb_wd_o, e_wd);
            check("pend", pend_o, e_pend);
            check("alu_stall", alu_stall_o, e_stall);
            check("lsu_ready", lsu_ready_o, e_ready);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        alu_valid_i = 1'b0; alu_rw_i = '0; alu_wd_i = '0;
        lsu_valid_i = 1'b0; lsu_rw_i = '0; lsu_wd_i = '0;
        ld_issue_i  = 1'b0; ld_issue_rw_i = '0;
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        repeat (3) step();
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_pend", pend_o, 0);
        check("rst_ready", lsu_ready_o, 0);
        check("rst_stall", alu_stall_o, 0);
        rst_ni = 1'b1;
        step();
        check("ready_after_release", lsu_ready_o, 1);

        // ALU only
        alu_valid_i = 1'b1; alu_rw_i = 5'd5; alu_wd_i = 128'hA5;
        step();
        alu_valid_i = 1'b0;
        check("t1_valid", wb_valid_o, 1);
        check("t1_we", wb_we_o, 1);
        check("t1_rw", wb_rw_o, 5);
        check("t1_wd", wb_wd_o, 128'hA5);
        step();
        check("t1_valid_gone", wb_valid_o, 0);
        check("t1_rw_hold", wb_rw_o, 5);

        // Load path: issue, return two cycles later, write back two cycles after that
        ld_issue_i = 1'b1; ld_issue_rw_i = 5'd7;
        step();
        ld_issue_i = 1'b0;
        check("t2_pend7_set", pend_o[7], 1);
        step();
        lsu_valid_i = 1'b1; lsu_rw_i = 5'd7; lsu_wd_i = 128'h1234;
        step();
        lsu_valid_i = 1'b0;
        check("t2_no_bypass", wb_valid_o, 0);
        step();
        check("t2_valid", wb_valid_o, 1);
        check("t2_rw", wb_rw_o, 7);
        check("t2_wd", wb_wd_o, 128'h1234);
        check("t2_pend7_clr", pend_o[7], 0);

        // Fill FIFO under continuous ALU traffic; starvation guard forces the head out
        for (int k = 0; k < 20; k++) begin
            alu_valid_i = !e_stall;
            alu_rw_i    = RW'(10 + k);
            alu_wd_i    = 128'(k);
            lsu_valid_i = (k < 4);
            lsu_rw_i    = RW'(20 + k);
            lsu_wd_i    = 128'(256 + k);
            step();
            if (k == 3) check("t3_ready_full", lsu_ready_o, 0);
            if (k == 4) check("t3_stall", alu_stall_o, 1);
            if (k == 5) begin
                check("t3_head_rw", wb_rw_o, 20);
                check("t3_head_wd", wb_wd_o, 128'h100);
                check("t3_stall_one_cycle", alu_stall_o, 0);
                check("t3_ready_back", lsu_ready_o, 1);
            end
        end
        idle_inputs();
        repeat (6) step();

        // Register 0: request issued without write enable; load issue to r0 ignored
        alu_valid_i = 1'b1; alu_rw_i = '0; alu_wd_i = 128'h77;
        ld_issue_i = 1'b1; ld_issue_rw_i = '0;
        step();
        idle_inputs();
        check("t4_valid", wb_valid_o, 1);
        check("t4_we", wb_we_o, 0);
        check("t4_pend", pend_o, 0);

        // Set/clear race on r3
        ld_issue_i = 1'b1; ld_issue_rw_i = 5'd3;
        step();
        ld_issue_i = 1'b0;
        lsu_valid_i = 1'b1; lsu_rw_i = 5'd3; lsu_wd_i = 128'h33;
        step();
        lsu_valid_i = 1'b0;
        ld_issue_i = 1'b1; ld_issue_rw_i = 5'd3;
        step();
        ld_issue_i = 1'b0;
        check("t5_wb_rw", wb_rw_o, 3);
        check("t5_pend3", pend_o[3], 1);
        step();
        check("t5_pend3_held", pend_o[3], 1);

        // Reset with three loads queued behind ALU traffic
        for (int k = 0; k < 3; k++) begin
            ld_issue_i = 1'b1; ld_issue_rw_i = RW'(9 + k);
            step();
        end
        ld_issue_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            alu_valid_i = 1'b1; alu_rw_i = 5'd1; alu_wd_i = 128'(k + 1);
            lsu_valid_i = (k < 3); lsu_rw_i = RW'(9 + k); lsu_wd_i = 128'(176 + k);
            step();
        end
        idle_inputs();
        check("t6_pend_before", pend_o, 32'h0000_0E08);
        #2 rst_ni = 1'b0;
        #1;
        check("t6_rst_valid", wb_valid_o, 0);
        check("t6_rst_rw", wb_rw_o, 0);
        check("t6_rst_wd", wb_wd_o, 0);
        check("t6_rst_pend", pend_o, 0);
        check("t6_rst_ready", lsu_ready_o, 0);
        check("t6_rst_stall", alu_stall_o, 0);
        step();
        rst_ni = 1'b1;
        step();
        check("t6_ready", lsu_ready_o, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("t6_no_wb", wb_valid_o, 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
